// File: rtl/reg_ctx_sequencer.sv
// reg_ctx_sequencer: context save/restore sequencer between the 16x8 register file and a data-memory stack
//
// Saves registers FIRST_REG..NUM_REGS-1 onto a downward-growing stack on save_req
// and pops them back (LIFO) on restore_req. While busy it owns register-file read
// port A and the register-file write port.
//
// Optional feature: define REG_CTX_STACK_GUARD_EN to refuse requests that would
// overflow/underflow the stack and flag them on the sticky err output.
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   save_req, restore_req      start requests, sampled only in IDLE
//   busy, done, err, sp        status: busy in SAVE/RESTORE, done pulse, guard error, stack pointer
//   rf_read_addr/rf_read_data  register-file read port A
//   rf_write_*                 register-file write port
//   mem_*                      data-memory request/response
module reg_ctx_sequencer #(
    parameter int         NUM_REGS  = 16,
    parameter int         FIRST_REG = 0,
    parameter logic [7:0] SP_RESET  = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       save_req,
    input  logic       restore_req,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] sp,
    output logic [3:0] rf_read_addr,
    input  logic [7:0] rf_read_data,
    output logic [3:0] rf_write_addr,
    output logic [7:0] rf_write_data,
    output logic       rf_write_enable,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       mem_re,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready
);
    localparam int         C     = NUM_REGS - FIRST_REG;
    localparam logic [3:0] FIRST = 4'(FIRST_REG);
    localparam logic [3:0] LAST  = 4'(NUM_REGS - 1);

    typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

    state_t     state_q;
    logic [7:0] sp_q;
    logic [3:0] idx_q;
    logic       err_q;
    logic       save_ok;
    logic       restore_ok;
    logic       in_save;
    logic       in_restore;

`ifdef REG_CTX_STACK_GUARD_EN
    // Compare in 9 bits so the room/underflow checks never wrap.
    assign save_ok    = ({1'b0, sp_q} + 9'd1) >= 9'(C);
    assign restore_ok = ({1'b0, sp_q} + 9'(C)) <= 9'h0FF;
`else
    assign save_ok    = 1'b1;
    assign restore_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            sp_q    <= SP_RESET;
            idx_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (save_req) begin
                        if (save_ok) begin
                            state_q <= SAVE;
                            idx_q   <= FIRST;
                            err_q   <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (restore_req) begin
                        if (restore_ok) begin
                            state_q <= RESTORE;
                            idx_q   <= LAST;
                            err_q   <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SAVE: begin
                    if (mem_ready) begin
                        sp_q  <= sp_q - 8'd1;
                        idx_q <= idx_q + 4'd1;
                        if (idx_q == LAST) state_q <= DONE;
                    end
                end
                RESTORE: begin
                    if (mem_ready) begin
                        sp_q  <= sp_q + 8'd1;
                        idx_q <= idx_q - 4'd1;
                        if (idx_q == FIRST) state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from registered state; gating with reset makes an
    // abort take effect in the very cycle reset is asserted (no further writes).
    assign in_save         = (state_q == SAVE) && reset;
    assign in_restore      = (state_q == RESTORE) && reset;
    assign busy            = in_save || in_restore;
    assign done            = (state_q == DONE) && reset;
    assign err             = err_q;
    assign sp              = sp_q;
    assign rf_read_addr    = in_save ? idx_q : 4'd0;
    assign mem_addr        = in_save ? sp_q : in_restore ? sp_q + 8'd1 : 8'd0;
    assign mem_wdata       = in_save ? rf_read_data : 8'd0;
    assign mem_we          = in_save;
    assign mem_re          = in_restore;
    assign rf_write_enable = in_restore && mem_ready;
    assign rf_write_addr   = rf_write_enable ? idx_q : 4'd0;
    assign rf_write_data   = rf_write_enable ? mem_rdata : 8'd0;
endmodule

// File: tb/tb_reg_ctx_sequencer.sv
// tb_reg_ctx_sequencer: directed self-checking bench for reg_ctx_sequencer
module tb_reg_ctx_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       save_req = 1'b0;
    logic       restore_req = 1'b0;
    logic       busy, done, err;
    logic [7:0] sp;
    logic [3:0] rf_read_addr, rf_write_addr;
    logic [7:0] rf_read_data, rf_write_data;
    logic       rf_write_enable;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we, mem_re, mem_ready;

    logic [7:0] rf [16];
    logic [7:0] mem [256];
    logic [1:0] rf_cmd = 2'd0;
    logic       mem_clr = 1'b0;
    logic       log_clr = 1'b0;
    int         wait_n = 0;
    int         ready_cnt = 0;
    int         rd_n = 0, wr_n = 0, we_cnt = 0, done_cnt = 0, viol = 0;
    logic       re_seen = 1'b0;
    logic [7:0] rd_log [16];
    logic [3:0] wr_log [16];
    logic       p_v = 1'b0;
    logic [7:0] p_addr = 8'd0, p_data = 8'd0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_ctx_sequencer dut (
        .clk(clk), .reset(reset), .save_req(save_req), .restore_req(restore_req),
        .busy(busy), .done(done), .err(err), .sp(sp),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .rf_write_enable(rf_write_enable),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    assign rf_read_data = rf[rf_read_addr];
    assign mem_rdata    = mem[mem_addr];
    assign mem_ready    = (wait_n == 0) || (ready_cnt == wait_n);

    // Register file, memory and transaction log model.
    always @(posedge clk) begin
        if (rf_cmd == 2'd1) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'(8'h10 + i);
        end else if (rf_cmd == 2'd2) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
        end else if (rf_write_enable) begin
            rf[rf_write_addr] <= rf_write_data;
        end
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_we && mem_ready) begin
            mem[mem_addr] <= mem_wdata;
        end
        ready_cnt <= (mem_we || mem_re) ? (mem_ready ? 0 : ready_cnt + 1) : 0;
        p_v    <= mem_we && !mem_ready;
        p_addr <= mem_addr;
        p_data <= mem_wdata;
        if (log_clr) begin
            rd_n <= 0; wr_n <= 0; we_cnt <= 0; done_cnt <= 0; viol <= 0; re_seen <= 1'b0;
        end else begin
            if (mem_re && mem_ready && rd_n < 16) begin
                rd_log[rd_n] <= mem_addr;
                rd_n <= rd_n + 1;
            end
            if (rf_write_enable && wr_n < 16) begin
                wr_log[wr_n] <= rf_write_addr;
                wr_n <= wr_n + 1;
            end
            if (mem_we && mem_ready) we_cnt <= we_cnt + 1;
            if (mem_re) re_seen <= 1'b1;
            if (done) done_cnt <= done_cnt + 1;
            if (p_v && (!mem_we || mem_addr != p_addr || mem_wdata != p_data)) viol <= viol + 1;
        end
    end

`ifdef REG_CTX_STACK_GUARD_EN
    logic       g_save = 1'b0;
    logic       g_busy, g_done, g_err, g_rfwe, g_we, g_re;
    logic [7:0] g_sp, g_wd, g_ma, g_mw;
    logic [3:0] g_ra, g_wa;
    reg_ctx_sequencer #(.SP_RESET(8'h08)) dut_g (
        .clk(clk), .reset(reset), .save_req(g_save), .restore_req(1'b0),
        .busy(g_busy), .done(g_done), .err(g_err), .sp(g_sp),
        .rf_read_addr(g_ra), .rf_read_data(8'h00),
        .rf_write_addr(g_wa), .rf_write_data(g_wd), .rf_write_enable(g_rfwe),
        .mem_addr(g_ma), .mem_wdata(g_mw), .mem_we(g_we), .mem_re(g_re),
        .mem_rdata(8'h00), .mem_ready(1'b1)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_log();
        log_clr = 1'b1;
        step();
        log_clr = 1'b0;
    endtask

    // Called in the first cycle after the request edge; returns the cycle index
    // (1-based from that edge) in which done was seen and the busy-cycle count.
    task automatic run_to_done(input int limit, output int k, output int bc);
        k = 1;
        bc = 0;
        while (!done && k < limit) begin
            if (busy) bc++;
            step();
            k++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int k, bc, bad;
        rf_cmd = 2'd1;
        mem_clr = 1'b1;
        log_clr = 1'b1;
        step();
        rf_cmd = 2'd0;
        mem_clr = 1'b0;
        log_clr = 1'b0;
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sp", 32'(sp), 32'hFF);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b1;
        step();

`ifdef REG_CTX_STACK_GUARD_EN
        g_save = 1'b1;
        step();
        g_save = 1'b0;
        chk("g_save_we", 32'(g_we), 32'd0);
        chk("g_save_busy", 32'(g_busy), 32'd0);
        chk("g_save_err", 32'(g_err), 32'd1);
        chk("g_save_sp", 32'(g_sp), 32'h08);
`endif

        // Full save with ready tied high.
        save_req = 1'b1;
        step();
        save_req = 1'b0;
        run_to_done(200, k, bc);
        chk("save_done_cycle", 32'(k), 32'd17);
        chk("save_busy_cycles", 32'(bc), 32'd16);
        chk("save_sp", 32'(sp), 32'hEF);
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[8'hFF - i] !== 8'(8'h10 + i)) bad++;
        chk("save_mem_image", 32'(bad), 32'd0);
        step();
        chk("save_done_pulse", 32'(done), 32'd0);
        chk("save_idle_busy", 32'(busy), 32'd0);

        // Restore into a cleared register file.
        rf_cmd = 2'd2;
        log_clr = 1'b1;
        step();
        rf_cmd = 2'd0;
        log_clr = 1'b0;
        restore_req = 1'b1;
        step();
        restore_req = 1'b0;
        run_to_done(200, k, bc);
        chk("rest_done_cycle", 32'(k), 32'd17);
        chk("rest_sp", 32'(sp), 32'hFF);
        chk("rest_reads", 32'(rd_n), 32'd16);
        chk("rest_writes", 32'(wr_n), 32'd16);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (rd_log[i] !== 8'(8'hF0 + i)) bad++;
            if (wr_log[i] !== 4'(15 - i)) bad++;
            if (rf[i] !== 8'(8'h10 + i)) bad++;
        end
        chk("rest_order_and_rf", 32'(bad), 32'd0);

        // Save with two wait states per transfer.
        wait_n = 2;
        mem_clr = 1'b1;
        log_clr = 1'b1;
        step();
        mem_clr = 1'b0;
        log_clr = 1'b0;
        save_req = 1'b1;
        step();
        save_req = 1'b0;
        run_to_done(400, k, bc);
        chk("wait_busy_cycles", 32'(bc), 32'd48);
        chk("wait_stable", 32'(viol), 32'd0);
        chk("wait_sp", 32'(sp), 32'hEF);
        chk("wait_mem_F0", 32'(mem[8'hF0]), 32'h1F);
        wait_n = 0;
        step();

        // Both requests together: save wins, restore during busy ignored.
        clear_log();
        save_req = 1'b1;
        restore_req = 1'b1;
        step();
        save_req = 1'b0;
        run_to_done(200, k, bc);
        restore_req = 1'b0;
        step();
        step();
        chk("both_no_re", 32'(re_seen), 32'd0);
        chk("both_we_cnt", 32'(we_cnt), 32'd16);
        chk("both_sp", 32'(sp), 32'hDF);
        chk("both_idle", 32'(busy), 32'd0);

        // Reset in the middle of a save, after five transfers.
        reset = 1'b0;
        mem_clr = 1'b1;
        step();
        reset = 1'b1;
        mem_clr = 1'b0;
        clear_log();
        save_req = 1'b1;
        step();
        save_req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b0;
        #1;
        chk("abort_we_now", 32'(mem_we), 32'd0);
        step();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sp", 32'(sp), 32'hFF);
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_we_cnt", 32'(we_cnt), 32'd5);
        chk("abort_mem_FB", 32'(mem[8'hFB]), 32'h14);
        chk("abort_mem_FA", 32'(mem[8'hFA]), 32'h00);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // Restore from the reset stack pointer: wraps silently, or is refused by the guard.
        clear_log();
        restore_req = 1'b1;
        step();
        restore_req = 1'b0;
`ifdef REG_CTX_STACK_GUARD_EN
        chk("guard_rest_busy", 32'(busy), 32'd0);
        chk("guard_rest_err", 32'(err), 32'd1);
        chk("guard_rest_sp", 32'(sp), 32'hFF);
        save_req = 1'b1;
        step();
        save_req = 1'b0;
        chk("guard_err_clear", 32'(err), 32'd0);
        run_to_done(200, k, bc);
        chk("guard_save_sp", 32'(sp), 32'hEF);
`else
        run_to_done(200, k, bc);
        chk("wrap_sp", 32'(sp), 32'h0F);
        chk("wrap_first_addr", 32'(rd_log[0]), 32'h00);
        chk("wrap_err", 32'(err), 32'd0);
`endif
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
